// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: sticky request capture with masked highest-index grant over valid/ready
module irq_pending_arbiter #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       idx_ready,
    input  logic       clr_lost,
    output logic       idx_valid,
    output logic [2:0] idx,
    output logic [7:0] pend,
    output logic [7:0] lost
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;
    logic [0:0] state_q, state_d;
    logic [7:0] req_d_q, pend_q, pend_d, lost_q, lost_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] evt, clr, elig;
    logic [2:0] hi;
    logic       accept;
    always_comb begin
        evt    = EDGE_MODE ? (req & ~req_d_q) : req;
        accept = (state_q == OFFER) && idx_ready;
        clr    = accept ? (8'b1 << idx_q) : 8'b0;
        pend_d = evt | (pend_q & ~clr);
        // a loss recorded in the clear cycle survives the clear
        lost_d = (clr_lost ? 8'b0 : lost_q) | (evt & pend_q & ~clr);
        elig   = pend_q & mask;
        hi     = 3'd0;
        for (int i = 0; i < 8; i++)
            if (elig[i]) hi = i[2:0];
        state_d = state_q == IDLE ? ((elig != 8'b0) ? OFFER : IDLE) : (accept ? IDLE : OFFER);
        idx_d   = (state_q == IDLE && elig != 8'b0) ? hi : idx_q;
    end
    always_ff @(posedge clk) begin
        req_d_q <= req;
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 8'b0;
            lost_q  <= 8'b0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            lost_q  <= lost_d;
            idx_q   <= idx_d;
        end
    end
    assign idx_valid = (state_q == OFFER);
    assign idx       = idx_q;
    assign pend      = pend_q;
    assign lost      = lost_q;
endmodule
